memory_arbiter: RTL and testbench

Shares one single-port unified memory between the CPU instruction-fetch port and its load/store data port. It sits between the core and the memory model. It grants one request at a time, using round-robin when both ports request together, and sequences the memory through a fixed-latency access. It then returns the read data or a write acknowledge to the port that was granted.

---
 rtl/cpu_types_pkg.sv | 26 ++
 rtl/memory_arbiter.sv | 154 +++++++++++++++
 tb/tb_memory_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU type definitions: memory access sizes plus the arbiter's
// state and requester encodings.
package cpu_types;

  // Access size presented to the unified memory.
  typedef enum logic [1:0] {
    MEM_BYTE = 2'd0,
    MEM_HALF = 2'd1,
    MEM_WORD = 2'd2
  } memory_mask_t;

  // Arbiter transaction sequence.
  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_WAIT   = 2'd2,
    ARB_RESP   = 2'd3
  } arbiter_state_t;

  // Port that owns (or last owned) the memory.
  typedef enum logic {
    REQ_FETCH = 1'b0,
    REQ_DATA  = 1'b1
  } requester_t;

endpackage

// File: rtl/memory_arbiter.sv
// memory_arbiter: shares one single-port fixed-latency memory between the
// instruction-fetch port and the load/store port. One transaction in flight;
// round-robin on simultaneous requests.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   if_req/if_addr             fetch request (held until if_gnt)
//   if_gnt/if_rvalid/if_rdata  fetch grant pulse, response pulse, word
//   d_req/d_we/d_addr/d_wdata/d_mask  load/store request (held until d_gnt)
//   d_gnt/d_rvalid/d_rdata     data grant pulse, response/ack pulse, word
//   mem_en/mem_we/mem_addr/mem_wdata/mem_mask  memory request side
//   mem_rdata                  memory read data, LATENCY cycles after mem_en
module memory_arbiter
  import cpu_types::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             if_req,
  input  logic [WIDTH-1:0] if_addr,
  output logic             if_gnt,
  output logic             if_rvalid,
  output logic [WIDTH-1:0] if_rdata,
  input  logic             d_req,
  input  logic             d_we,
  input  logic [WIDTH-1:0] d_addr,
  input  logic [WIDTH-1:0] d_wdata,
  input  memory_mask_t     d_mask,
  output logic             d_gnt,
  output logic             d_rvalid,
  output logic [WIDTH-1:0] d_rdata,
  output logic             mem_en,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output memory_mask_t     mem_mask,
  input  logic [WIDTH-1:0] mem_rdata
);

  localparam int unsigned CNT_W = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);

  if (LATENCY < 1) begin : g_latency_check
    $error("memory_arbiter: LATENCY must be at least 1");
  end

  arbiter_state_t   state_q, state_d;
  requester_t       last_grant_q, owner_q, winner;
  logic             grant_valid;
  logic             txn_we_q;
  logic [WIDTH-1:0] txn_addr_q, txn_wdata_q;
  memory_mask_t     txn_mask_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] if_rdata_q, d_rdata_q;

  // Round-robin pick; only meaningful when at least one request is high.
  function automatic requester_t pick(input logic f, input logic d,
                                      input requester_t last);
    if (f && d) return (last == REQ_DATA) ? REQ_FETCH : REQ_DATA;
    else if (d) return REQ_DATA;
    else        return REQ_FETCH;
  endfunction

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ARB_IDLE;
    else        state_q <= state_d;
  end

  // Next state, combinational grant and state-decoded strobes.
  always_comb begin
    state_d     = state_q;
    winner      = pick(if_req, d_req, last_grant_q);
    grant_valid = 1'b0;
    if_gnt      = 1'b0;
    d_gnt       = 1'b0;
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    if_rvalid   = 1'b0;
    d_rvalid    = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (rst_n && (if_req || d_req)) begin
          grant_valid = 1'b1;
          if_gnt      = (winner == REQ_FETCH);
          d_gnt       = (winner == REQ_DATA);
          state_d     = ARB_ACCESS;
        end
      end
      ARB_ACCESS: begin
        mem_en  = rst_n;
        mem_we  = rst_n && txn_we_q;
        state_d = ARB_WAIT;
      end
      ARB_WAIT: begin
        if (cnt_q == '0) state_d = ARB_RESP;
      end
      ARB_RESP: begin
        if_rvalid = rst_n && (owner_q == REQ_FETCH);
        d_rvalid  = rst_n && (owner_q == REQ_DATA);
        state_d   = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Transaction latch, wait counter and per-port response capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant_q <= REQ_DATA;
      owner_q      <= REQ_FETCH;
      txn_we_q     <= 1'b0;
      txn_addr_q   <= '0;
      txn_wdata_q  <= '0;
      txn_mask_q   <= MEM_WORD;
      cnt_q        <= '0;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
    end else begin
      if (grant_valid) begin
        last_grant_q <= winner;
        owner_q      <= winner;
        if (winner == REQ_DATA) begin
          txn_we_q    <= d_we;
          txn_addr_q  <= d_addr;
          txn_wdata_q <= d_wdata;
          txn_mask_q  <= d_mask;
        end else begin
          // Fetches are always aligned word reads.
          txn_we_q    <= 1'b0;
          txn_addr_q  <= if_addr & ~WIDTH'(3);
          txn_wdata_q <= '0;
          txn_mask_q  <= MEM_WORD;
        end
      end
      if (state_q == ARB_ACCESS) cnt_q <= CNT_W'(LATENCY - 1);
      if (state_q == ARB_WAIT) begin
        if (cnt_q == '0) begin
          if (owner_q == REQ_FETCH) if_rdata_q <= txn_we_q ? '0 : mem_rdata;
          else                      d_rdata_q  <= txn_we_q ? '0 : mem_rdata;
        end else begin
          cnt_q <= cnt_q - CNT_W'(1);
        end
      end
    end
  end

  assign mem_addr  = txn_addr_q;
  assign mem_wdata = txn_wdata_q;
  assign mem_mask  = txn_mask_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Scoreboard bench for memory_arbiter: LATENCY=1 instance with a memory
// model, plus a LATENCY=3 instance driven with a one-cycle-valid read.
module tb_memory_arbiter;
  import cpu_types::*;

  typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata;
                   memory_mask_t mask; logic [31:0] exp; } vec_t;
  typedef struct { logic is_data; logic [31:0] rdata; int cyc; } rsp_t;
  typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata;
                   memory_mask_t mask; int cyc; } memx_t;
  typedef struct { logic is_data; int cyc; } gnt_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  // LATENCY=1 instance
  logic         if_req, if_gnt, if_rvalid;
  logic [31:0]  if_addr, if_rdata;
  logic         d_req, d_we, d_gnt, d_rvalid;
  logic [31:0]  d_addr, d_wdata, d_rdata;
  memory_mask_t d_mask, mem_mask;
  logic         mem_en, mem_we;
  logic [31:0]  mem_addr, mem_wdata, mem_rdata;

  // LATENCY=3 instance
  logic         l3_if_req, l3_if_gnt, l3_if_rvalid;
  logic [31:0]  l3_if_addr, l3_if_rdata;
  logic         l3_d_req, l3_d_we, l3_d_gnt, l3_d_rvalid;
  logic [31:0]  l3_d_addr, l3_d_wdata, l3_d_rdata;
  memory_mask_t l3_d_mask, l3_mem_mask;
  logic         l3_mem_en, l3_mem_we;
  logic [31:0]  l3_mem_addr, l3_mem_wdata, l3_mem_rdata;

  logic [31:0] mem_words [0:127];
  vec_t  fv [2];
  vec_t  dv [2];
  rsp_t  rsp_q [$];
  memx_t mem_q [$];
  gnt_t  gnt_log [$];

  memory_arbiter #(.WIDTH(32), .LATENCY(1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_mask(d_mask), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_mask(mem_mask), .mem_rdata(mem_rdata)
  );

  memory_arbiter #(.WIDTH(32), .LATENCY(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .if_req(l3_if_req), .if_addr(l3_if_addr), .if_gnt(l3_if_gnt),
    .if_rvalid(l3_if_rvalid), .if_rdata(l3_if_rdata),
    .d_req(l3_d_req), .d_we(l3_d_we), .d_addr(l3_d_addr),
    .d_wdata(l3_d_wdata), .d_mask(l3_d_mask), .d_gnt(l3_d_gnt),
    .d_rvalid(l3_d_rvalid), .d_rdata(l3_d_rdata),
    .mem_en(l3_mem_en), .mem_we(l3_mem_we), .mem_addr(l3_mem_addr),
    .mem_wdata(l3_mem_wdata), .mem_mask(l3_mem_mask),
    .mem_rdata(l3_mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Single-cycle memory model for the LATENCY=1 instance.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        case (mem_mask)
          MEM_BYTE: mem_words[mem_addr[8:2]][{mem_addr[1:0], 3'b000} +: 8]
                      <= mem_wdata[{mem_addr[1:0], 3'b000} +: 8];
          MEM_HALF: mem_words[mem_addr[8:2]][{mem_addr[1], 4'b0000} +: 16]
                      <= mem_wdata[{mem_addr[1], 4'b0000} +: 16];
          default:  mem_words[mem_addr[8:2]] <= mem_wdata;
        endcase
      end else begin
        mem_rdata <= mem_words[mem_addr[8:2]];
      end
    end
  end

  function automatic void chk(input bit ok, input string name,
                              input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h (cycle %0d)", name, got, exp, cyc);
    end
  endfunction

  // Response monitor: pops the scoreboard on every rvalid pulse.
  always @(posedge clk) begin
    #1;
    if (rst_n && (if_rvalid || d_rvalid)) begin
      if (rsp_q.size() == 0) begin
        chk(1'b0, "rsp_unexpected", {30'd0, d_rvalid, if_rvalid}, 32'd0);
      end else begin
        rsp_t e;
        logic [31:0] got;
        e = rsp_q.pop_front();
        got = e.is_data ? d_rdata : if_rdata;
        chk((if_rvalid != d_rvalid) && (d_rvalid == e.is_data) &&
            (got == e.rdata) && (cyc == e.cyc),
            e.is_data ? "rsp_data" : "rsp_fetch", got, e.rdata);
      end
    end
  end

  // Memory-side monitor: pops the expected access on every mem_en.
  always @(posedge clk) begin
    #1;
    if (rst_n && mem_en) begin
      if (mem_q.size() == 0) begin
        chk(1'b0, "mem_unexpected", mem_addr, 32'd0);
      end else begin
        memx_t m;
        m = mem_q.pop_front();
        chk((mem_we == m.we) && (mem_addr == m.addr) &&
            (mem_wdata == m.wdata) && (mem_mask == m.mask) && (cyc == m.cyc),
            "mem_access", mem_addr, m.addr);
        if (mem_wdata != m.wdata || mem_mask != m.mask || mem_we != m.we)
          $display("  detail: wdata=%h/%h mask=%0d/%0d we=%b/%b", mem_wdata,
                   m.wdata, mem_mask, m.mask, mem_we, m.we);
      end
    end
  end

  task automatic log_grant(input logic is_data, input vec_t v);
    gnt_t g; memx_t m; rsp_t r;
    g.is_data = is_data; g.cyc = cyc;
    gnt_log.push_back(g);
    m.we    = is_data ? v.we : 1'b0;
    m.addr  = is_data ? v.addr : (v.addr & 32'hFFFF_FFFC);
    m.wdata = is_data ? v.wdata : 32'd0;
    m.mask  = is_data ? v.mask : MEM_WORD;
    m.cyc   = cyc + 1;
    mem_q.push_back(m);
    r.is_data = is_data; r.rdata = v.exp; r.cyc = cyc + 3;
    rsp_q.push_back(r);
  endtask

  task automatic fetch_port(input int n);
    for (int i = 0; i < n; i++) begin
      int k = 0;
      if_req = 1'b1; if_addr = fv[i].addr;
      #1;
      while (!if_gnt && k < 40) begin @(negedge clk); #1; k++; end
      if (!if_gnt) begin
        chk(1'b0, "fetch_gnt_timeout", 32'(k), 32'd40);
        if_req = 1'b0;
        return;
      end
      log_grant(1'b0, fv[i]);
      @(negedge clk);
    end
    if_req = 1'b0;
  endtask

  task automatic data_port(input int n);
    for (int i = 0; i < n; i++) begin
      int k = 0;
      d_req = 1'b1; d_we = dv[i].we; d_addr = dv[i].addr;
      d_wdata = dv[i].wdata; d_mask = dv[i].mask;
      #1;
      while (!d_gnt && k < 40) begin @(negedge clk); #1; k++; end
      if (!d_gnt) begin
        chk(1'b0, "data_gnt_timeout", 32'(k), 32'd40);
        d_req = 1'b0;
        return;
      end
      log_grant(1'b1, dv[i]);
      @(negedge clk);
    end
    d_req = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while ((rsp_q.size() != 0 || mem_q.size() != 0) && k < 40) begin
      @(negedge clk); k++;
    end
    chk(rsp_q.size() == 0 && mem_q.size() == 0, "drain",
        32'(rsp_q.size() + mem_q.size()), 32'd0);
  endtask

  task automatic check_reset(input string name);
    chk(!if_gnt && !d_gnt && !if_rvalid && !d_rvalid && !mem_en && !mem_we &&
        mem_addr == 32'd0 && mem_wdata == 32'd0 && if_rdata == 32'd0 &&
        d_rdata == 32'd0 && mem_mask == MEM_WORD, name,
        {26'd0, if_gnt, d_gnt, if_rvalid, d_rvalid, mem_en, mem_we}, 32'd0);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    memx_t m;
    int t;
    int issue_c;
    rst_n = 1'b0;
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_mask = MEM_WORD;
    l3_if_req = 1'b0; l3_if_addr = '0;
    l3_d_req = 1'b0; l3_d_we = 1'b0; l3_d_addr = '0; l3_d_wdata = '0;
    l3_d_mask = MEM_WORD; l3_mem_rdata = '0;
    for (int i = 0; i < 128; i++) mem_words[i] = 32'h0;
    mem_words[3]  = 32'hCAFE_F00D;  // 0x00C
    mem_words[16] = 32'h1122_3344;  // 0x040
    mem_words[65] = 32'h0000_0013;  // 0x104
    mem_words[66] = 32'h00A0_0093;  // 0x108
    mem_words[67] = 32'h0000_0537;  // 0x10C
    mem_words[68] = 32'h5555_AAAA;  // 0x110

    fv[0] = '{1'b0, 32'h0000_0106, 32'h0, MEM_WORD, 32'h0000_0013};
    fv[1] = '{1'b0, 32'h0000_010A, 32'h0, MEM_WORD, 32'h00A0_0093};
    dv[0] = '{1'b0, 32'h0000_000C, 32'h1234_5678, MEM_WORD, 32'hCAFE_F00D};
    dv[1] = '{1'b1, 32'h0000_0040, 32'hDEAD_BEEF, MEM_BYTE, 32'h0};

    // Reset with both requests held, then contention F,D,F,D.
    fork
      begin
        @(negedge clk); check_reset("reset_cycle0");
        @(negedge clk); check_reset("reset_cycle1");
        rst_n = 1'b1;
        #1;
        chk(if_gnt && !d_gnt, "first_gnt_fetch", {30'd0, if_gnt, d_gnt},
            32'h2);
      end
      fetch_port(2);
      data_port(2);
    join
    drain();

    chk(gnt_log.size() == 4, "grant_count", 32'(gnt_log.size()), 32'd4);
    for (int i = 0; i < gnt_log.size() && i < 4; i++) begin
      chk(gnt_log[i].is_data == i[0], "grant_order",
          {31'd0, gnt_log[i].is_data}, {31'd0, i[0]});
      if (i > 0)
        chk(gnt_log[i].cyc - gnt_log[i-1].cyc == 4, "grant_spacing",
            32'(gnt_log[i].cyc - gnt_log[i-1].cyc), 32'd4);
    end
    chk(mem_words[16] == 32'h1122_33EF, "store_byte_0x40", mem_words[16],
        32'h1122_33EF);

    // Reset while the fetch transaction is in WAIT.
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h0000_0112;
    #1;
    chk(if_gnt && !d_gnt, "midwait_gnt", {31'd0, if_gnt}, 32'd1);
    t = cyc;
    m.we = 1'b0; m.addr = 32'h0000_0110; m.wdata = 32'h0; m.mask = MEM_WORD;
    m.cyc = t + 1;
    if (if_gnt) mem_q.push_back(m);
    @(negedge clk); if_req = 1'b0;
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    #1;
    chk(if_rdata == 32'd0, "midwait_rdata_cleared", if_rdata, 32'd0);
    for (int i = 0; i < 5; i++) begin
      chk(!if_rvalid && !d_rvalid, "midwait_no_rvalid",
          {30'd0, if_rvalid, d_rvalid}, 32'd0);
      @(negedge clk);
    end
    fv[0] = '{1'b0, 32'h0000_010C, 32'h0, MEM_WORD, 32'h0000_0537};
    issue_c = cyc;
    fetch_port(1);
    chk(gnt_log.size() == 5 && gnt_log[gnt_log.size()-1].cyc == issue_c,
        "post_reset_gnt_immediate", 32'(gnt_log[gnt_log.size()-1].cyc),
        32'(issue_c));
    drain();

    // LATENCY=3: read data valid only in the final WAIT cycle.
    @(negedge clk);
    l3_d_req = 1'b1; l3_d_addr = 32'h0000_0080; l3_d_we = 1'b0;
    l3_d_mask = MEM_WORD; l3_mem_rdata = 32'hBAD0_0000;
    #1;
    chk(l3_d_gnt && !l3_if_gnt, "l3_gnt", {30'd0, l3_if_gnt, l3_d_gnt},
        32'd1);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 1) l3_d_req = 1'b0;
      l3_mem_rdata = (c == 4) ? 32'hA5A5_5A5A : (32'hBAD0_0000 | 32'(c));
      #1;
      if (c == 1)
        chk(l3_mem_en && !l3_mem_we && l3_mem_addr == 32'h80 &&
            l3_mem_wdata == 32'h0 && l3_mem_mask == MEM_WORD, "l3_mem_en",
            l3_mem_addr, 32'h80);
      chk(l3_d_rvalid == (c == 5) && !l3_if_rvalid, "l3_rvalid_timing",
          {30'd0, l3_if_rvalid, l3_d_rvalid}, {31'd0, c == 5});
      if (c == 5) begin
        chk(l3_d_rdata == 32'hA5A5_5A5A, "l3_rdata", l3_d_rdata,
            32'hA5A5_5A5A);
        chk(l3_if_rdata == 32'h0, "l3_if_rdata_untouched", l3_if_rdata,
            32'h0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
